// File: rtl/wdg_pkg.sv
// wdg_pkg: watchdog state encoding and default sizing/key constants (WDG_WINDOW_EN enables windowed kicks in wdg_timer)
package wdg_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int PRESC_W_DEF = 8;
  localparam logic [15:0] KICK_KEY_DEF = 16'hC0DE;
  typedef enum logic [1:0] {IDLE, RUN, TO} state_t;
endpackage

// File: rtl/wdg_prescaler.sv
// wdg_prescaler: divides clk into ticks every i_presc+1 cycles while running; cleared on kick or when stopped
module wdg_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               sys_res,
  input  logic               i_run,
  input  logic               i_clr,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_tick
);
  logic [PRESC_W-1:0] r_div;
  assign o_tick = i_run && (r_div >= i_presc);
  // divider restarts on reset, kick, idle/timeout or after each tick
  always_ff @(posedge clk)
    r_div <= (sys_res || i_clr || !i_run || o_tick) ? '0 : r_div + PRESC_W'(1);
endmodule

// File: rtl/wdg_timer.sv
// wdg_timer: keyed watchdog with pre-timeout warning; define WDG_WINDOW_EN to reject kicks below cfg_window
module wdg_timer
  import wdg_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int          PRESC_W  = PRESC_W_DEF,
  parameter logic [15:0] KICK_KEY = KICK_KEY_DEF
) (
  input  logic               clk,
  input  logic               sys_res,
  input  logic               en,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic [CNT_W-1:0]   cfg_timeout,
  input  logic [CNT_W-1:0]   cfg_warn,
  input  logic [CNT_W-1:0]   cfg_window,
  input  logic               kick,
  input  logic [15:0]        kick_key,
  output logic               kick_ack,
  output logic               wdg_warn,
  output logic               wdg_to,
  output logic [CNT_W-1:0]   cnt_o
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ack, r_warn, r_to;
  logic             w_tick, w_win_ok, w_kick_ok, w_kick_bad, w_expire;
`ifdef WDG_WINDOW_EN
  assign w_win_ok = r_cnt >= cfg_window;
`else
  assign w_win_ok = 1'b1;
`endif
  assign w_kick_ok  = (r_state == RUN) && kick && (kick_key == KICK_KEY) && w_win_ok;
  assign w_kick_bad = (r_state == RUN) && kick && !w_kick_ok;
  assign w_expire   = w_tick && (r_cnt >= cfg_timeout);
  wdg_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .sys_res (sys_res),
    .i_run   (r_state == RUN),
    .i_clr   (w_kick_ok),
    .i_presc (cfg_presc),
    .o_tick  (w_tick)
  );
  // next state and count; a valid kick outranks a coinciding timeout tick
  always_comb begin
    w_next = r_state;
    w_cnt_nxt = r_cnt;
    if (r_state == IDLE && en) begin
      w_next = RUN;
      w_cnt_nxt = '0;
    end else if (w_kick_ok) w_cnt_nxt = '0;
    else if (w_kick_bad || w_expire) w_next = TO;
    else if (w_tick) w_cnt_nxt = r_cnt + CNT_W'(1);
  end
  // state register; only sys_res leaves TO
  always_ff @(posedge clk)
    r_state <= sys_res ? IDLE : w_next;
  // registered outputs derived from next-cycle state so they never glitch
  always_ff @(posedge clk)
    if (sys_res) begin
      r_cnt  <= '0;
      r_ack  <= 1'b0;
      r_warn <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_ack  <= w_kick_ok;
      r_warn <= (w_next == RUN) && (cfg_warn != '0) && (w_cnt_nxt >= cfg_warn);
      r_to   <= w_next == TO;
    end
  assign kick_ack = r_ack;
  assign wdg_warn = r_warn;
  assign wdg_to   = r_to;
  assign cnt_o    = r_cnt;
endmodule
